bank_cmd_scheduler: RTL and testbench
=====================================

Name: bank_cmd_scheduler

Overview:
- Responder side of the bank FSM stall/issue handshake.
- Watches all per-bank FSMs and grants at most one *_CHECK bank per cycle by deasserting that bank's stall bit.
- Enforces DRAM timing (tRCD, tRP, tRAS, tRRD, tCCD, auto-precharge recovery).
- Registers the issuing bank's ba_addr onto the single DRAM command bus.

Parameters:
- NUM_BANKS, 8, number of bank FSMs (index = BA value)
- T_RCD, 3, ACT to RD/WR on the same bank, in cycles
- T_RP, 3, PRE to ACT on the same bank
- T_RAS, 6, ACT to PRE on the same bank
- T_RRD, 2, ACT to ACT on any bank
- T_CCD, 2, RD/WR to RD/WR on any bank
- T_AP, 6, RD/WR with auto-precharge to ACT on the same bank
- AP_BIT, 10, column address bit carrying the auto-precharge flag

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ba_state_i  in  NUM_BANKS*FSM_WIDTH2  packed bank_state_t per bank; bank b at [b*W +: W]
- ba_issue_i  in  NUM_BANKS  per-bank issue strobe
- ba_addr_i  in  NUM_BANKS*ADDR_BITS  per-bank row/column address
- stall_o  out  NUM_BANKS  per-bank stall; 0 = grant
- dram_cmd_o  out  3  dram_cmd_t: NOP/ACT/RD/WR/PRE
- dram_addr_o  out  ADDR_BITS  DRAM address
- dram_ba_o  out  BA_BITS  DRAM bank address
- proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0):
  - All counters 0, round-robin pointer 0.
  - dram_cmd_o=NOP, dram_addr_o=0, dram_ba_o=0, proto_err_o=0.
  - stall_o=all 1 while rst_n=0, combinationally forced.
- Request decode, per bank:
  - B_ACT_CHECK requests ACT; B_READ_CHECK requests RD; B_WRITE_CHECK requests WR; B_PRE_CHECK requests PRE.
  - Any other state is no request.
- Eligibility:
  - ACT: rp_cnt[b]==0 and rrd_cnt==0.
  - RD/WR: rcd_cnt[b]==0 and ccd_cnt==0.
  - PRE: ras_cnt[b]==0.
- Arbitration, combinational within the cycle:
  - Scan from the round-robin pointer upward with wrap-around; first eligible requester wins.
  - stall_o[winner]=0; every other bit is 1, including non-requesting banks.
  - At most one 0 bit per cycle.
  - Pointer is registered as winner+1 mod NUM_BANKS on a grant; held otherwise.
- Timing counters:
  - Loaded at the edge ending a grant cycle g with (T-1); decrement by 1 toward 0 each cycle, saturating at 0.
  - Dependent grant is therefore allowed no earlier than cycle g+T.
  - ACT grant loads rcd_cnt[b]=T_RCD-1, ras_cnt[b]=T_RAS-1, rrd_cnt=T_RRD-1.
  - RD/WR grant loads ccd_cnt=T_CCD-1.
  - PRE grant loads rp_cnt[b]=T_RP-1.
  - A load takes priority over the decrement.
  - Auto-precharge: on a cycle where ba_issue_i[b]=1 for an RD/WR and ba_addr_i[b][AP_BIT]=1, rp_cnt[b] loads T_AP-2, so ACT is allowed at grant+T_AP.
- Command bus:
  - The granted bank asserts ba_issue_i one cycle after its grant (cycle g+1).
  - At the end of cycle g+1, register dram_cmd_o = the command type latched at grant, dram_addr_o=ba_addr_i[b], dram_ba_o=b.
  - Grant-to-bus latency: 2 edges. The command is held for exactly one cycle, then NOP.
- Error handling:
  - More than one ba_issue_i bit set, or ba_issue_i set without a grant in the previous cycle: proto_err_o=1 (sticky until reset).
  - In that case the bus takes the lowest-index issuing bank.
- Grant with a requester leaving *_CHECK in the same cycle cannot occur: CHECK states exit only on stall=0.

Decomposition:
- userType_pkg (shared):
  - bank_state_t encodings (existing)
  - new dram_cmd_t: NOP=0, ACT=1, RD=2, WR=3, PRE=4
  - FSM_WIDTH2, ADDR_BITS, BA_BITS
- Sub-module bank_timing_ctr: one instance per bank.
  - Holds rcd/ras/rp counters with load/decrement.
  - Outputs act_ok, rw_ok, pre_ok.
- Global rrd/ccd counters and the arbiter stay in the top.

Test Plan:
1. Bank 2 in B_ACT_CHECK at cycle 0, then B_ACTIVE with ba_addr=0x155 at cycle 1, then B_READ_CHECK from cycle 2 -> stall_o[2]=0 at cycle 0; dram_cmd_o=ACT, addr=0x155, ba=2 in cycle 2; stall_o[2]=1 in cycle 2, =0 in cycle 3.
2. Banks 0 and 5 in B_ACT_CHECK at cycle 0, pointer 0 -> bank 0 granted at cycle 0; bank 5 stalled at cycle 1 (rrd); bank 5 granted at cycle 2.
3. Banks 1, 4, 6 continuously in B_READ_CHECK, counters clear, T_CCD=2, pointer 5 -> grant order 6, 1, 4, 6 at cycles 0, 2, 4, 6.
4. ACT granted to bank 3 at cycle 0, B_PRE_CHECK from cycle 2 -> stall_o[3]=1 in cycles 2..5, 0 at cycle 6; dram PRE on the bus at cycle 8.
5. WR issued with ba_addr bit10=1 on bank 7 at cycle 10 (grant at 9), B_ACT_CHECK from cycle 11 -> ACT grant no earlier than cycle 15.
6. rst_n dropped mid-cycle with counters nonzero and a command on the bus -> immediately dram_cmd_o=NOP, stall_o=0xFF, proto_err_o=0; after release, first requester is granted in the first cycle.
7. ba_issue_i=0x09 in one cycle -> proto_err_o=1 and stays 1; dram_ba_o=0.

Source files
------------

// File: rtl/bank_cmd_scheduler_pkg.sv
// bank_cmd_scheduler_pkg: shared bank FSM states, DRAM command codes and bus widths
package bank_cmd_scheduler_pkg;
  localparam int FSM_WIDTH2 = 4;
  localparam int ADDR_BITS = 13;
  localparam int BA_BITS = 3;
  typedef enum logic [FSM_WIDTH2-1:0] {
    B_IDLE = 4'd0, B_ACT_CHECK = 4'd1, B_ACTIVE = 4'd2, B_READ_CHECK = 4'd3, B_READ = 4'd4,
    B_WRITE_CHECK = 4'd5, B_WRITE = 4'd6, B_PRE_CHECK = 4'd7, B_PRE = 4'd8
  } bank_state_t;
  typedef enum logic [2:0] {NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4} dram_cmd_t;
endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// bank_cmd_scheduler_if: bank FSM stall/issue handshake plus DRAM command bus
// master: bank side (drives state/issue/addr); slave: scheduler (drives stall and DRAM bus)
interface bank_cmd_scheduler_if import bank_cmd_scheduler_pkg::*; #(parameter int NUM_BANKS = 8);
  logic [NUM_BANKS*FSM_WIDTH2-1:0] ba_state_i;
  logic [NUM_BANKS-1:0] ba_issue_i;
  logic [NUM_BANKS*ADDR_BITS-1:0] ba_addr_i;
  logic [NUM_BANKS-1:0] stall_o;
  dram_cmd_t dram_cmd_o;
  logic [ADDR_BITS-1:0] dram_addr_o;
  logic [BA_BITS-1:0] dram_ba_o;
  logic proto_err_o;
  modport master(output ba_state_i, ba_issue_i, ba_addr_i, input stall_o, dram_cmd_o, dram_addr_o, dram_ba_o, proto_err_o);
  modport slave(input ba_state_i, ba_issue_i, ba_addr_i, output stall_o, dram_cmd_o, dram_addr_o, dram_ba_o, proto_err_o);
endinterface

// File: rtl/bank_cmd_scheduler_bank_timing_ctr.sv
// bank_cmd_scheduler_bank_timing_ctr: per-bank tRCD/tRAS/tRP counters
// ports: clk, rst_n, ld_act/ld_pre/ld_ap load strobes; act_ok/rw_ok/pre_ok eligibility
module bank_cmd_scheduler_bank_timing_ctr #(
  parameter int T_RCD = 3,
  parameter int T_RP = 3,
  parameter int T_RAS = 6,
  parameter int T_AP = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_act,
  input  logic ld_pre,
  input  logic ld_ap,
  output logic act_ok,
  output logic rw_ok,
  output logic pre_ok
);
  localparam int CW = 8;
  logic [CW-1:0] rcd, ras, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rcd <= '0;
      ras <= '0;
      rp <= '0;
    end else begin
      rcd <= ld_act ? CW'(T_RCD-1) : rcd != 0 ? rcd - 1'b1 : rcd;
      ras <= ld_act ? CW'(T_RAS-1) : ras != 0 ? ras - 1'b1 : ras;
      // auto-precharge is loaded at issue (one cycle after grant), hence T_AP-2
      rp <= ld_ap ? CW'(T_AP-2) : ld_pre ? CW'(T_RP-1) : rp != 0 ? rp - 1'b1 : rp;
    end
  assign act_ok = rp == 0;
  assign rw_ok = rcd == 0;
  assign pre_ok = ras == 0;
endmodule

// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler: round-robin grant of one *_CHECK bank per cycle under DRAM timing
// ports: clk, rst_n (async active-low), bus (slave: bank states/issue/addr in; stall, DRAM cmd/addr/ba, proto_err out)
module bank_cmd_scheduler import bank_cmd_scheduler_pkg::*; #(
  parameter int NUM_BANKS = 8,
  parameter int T_RCD = 3,
  parameter int T_RP = 3,
  parameter int T_RAS = 6,
  parameter int T_RRD = 2,
  parameter int T_CCD = 2,
  parameter int T_AP = 6,
  parameter int AP_BIT = 10
) (
  input logic clk,
  input logic rst_n,
  bank_cmd_scheduler_if.slave bus
);
  localparam int PW = $clog2(NUM_BANKS);
  localparam int CW = 8;
  bank_state_t st [NUM_BANKS];
  logic [NUM_BANKS-1:0] req_act, req_rw, req_pre, act_ok, rw_ok, pre_ok, elig, ld_ap;
  logic [PW-1:0] ptr, win, iss_b;
  logic [CW-1:0] rrd, ccd;
  logic grant, gnt_v, err_now;
  dram_cmd_t win_cmd, cmd_q;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign st[b] = bank_state_t'(bus.ba_state_i[b*FSM_WIDTH2 +: FSM_WIDTH2]);
    assign req_act[b] = st[b] == B_ACT_CHECK;
    assign req_rw[b] = st[b] == B_READ_CHECK || st[b] == B_WRITE_CHECK;
    assign req_pre[b] = st[b] == B_PRE_CHECK;
    assign elig[b] = (req_act[b] && act_ok[b] && rrd == 0) || (req_rw[b] && rw_ok[b] && ccd == 0) || (req_pre[b] && pre_ok[b]);
    assign ld_ap[b] = bus.ba_issue_i[b] && gnt_v && (cmd_q == RD || cmd_q == WR) && bus.ba_addr_i[b*ADDR_BITS+AP_BIT];
    bank_cmd_scheduler_bank_timing_ctr #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_AP(T_AP)) u_ctr (
      .clk(clk),
      .rst_n(rst_n),
      .ld_act(grant && win == PW'(b) && req_act[b]),
      .ld_pre(grant && win == PW'(b) && req_pre[b]),
      .ld_ap(ld_ap[b]),
      .act_ok(act_ok[b]),
      .rw_ok(rw_ok[b]),
      .pre_ok(pre_ok[b])
    );
  end
  // descending scan so the requester closest above ptr is assigned last and wins
  always_comb begin
    grant = 1'b0;
    win = '0;
    iss_b = '0;
    for (int i = NUM_BANKS-1; i >= 0; i--) begin
      if (elig[(int'(ptr)+i) % NUM_BANKS]) begin
        grant = 1'b1;
        win = PW'((int'(ptr)+i) % NUM_BANKS);
      end
      if (bus.ba_issue_i[i]) iss_b = PW'(i);
    end
    win_cmd = req_act[win] ? ACT : st[win] == B_READ_CHECK ? RD : st[win] == B_WRITE_CHECK ? WR : PRE;
    err_now = (bus.ba_issue_i & (bus.ba_issue_i - 1'b1)) != 0 || (|bus.ba_issue_i && !gnt_v);
  end
  assign bus.stall_o = !rst_n ? '1 : ~({{(NUM_BANKS-1){1'b0}}, grant} << win);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      rrd <= '0;
      ccd <= '0;
      gnt_v <= 1'b0;
      cmd_q <= NOP;
      bus.dram_cmd_o <= NOP;
      bus.dram_addr_o <= '0;
      bus.dram_ba_o <= '0;
      bus.proto_err_o <= 1'b0;
    end else begin
      gnt_v <= grant;
      cmd_q <= win_cmd;
      if (grant) ptr <= win == PW'(NUM_BANKS-1) ? '0 : win + 1'b1;
      rrd <= grant && req_act[win] ? CW'(T_RRD-1) : rrd != 0 ? rrd - 1'b1 : rrd;
      ccd <= grant && req_rw[win] ? CW'(T_CCD-1) : ccd != 0 ? ccd - 1'b1 : ccd;
      bus.dram_cmd_o <= |bus.ba_issue_i && gnt_v ? cmd_q : NOP;
      if (|bus.ba_issue_i) begin
        bus.dram_addr_o <= bus.ba_addr_i[iss_b*ADDR_BITS +: ADDR_BITS];
        bus.dram_ba_o <= BA_BITS'(iss_b);
      end
      bus.proto_err_o <= bus.proto_err_o | err_now;
    end
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// tb_bank_cmd_scheduler: directed checks of grant order, timing and DRAM bus
module tb_bank_cmd_scheduler;
  import bank_cmd_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] gnt_prev, force_iss;
  logic [7:0] exp3 [7];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bank_cmd_scheduler_if #(.NUM_BANKS(8)) itf();
  bank_cmd_scheduler dut(.clk(clk), .rst_n(rst_n), .bus(itf));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic set_st(input int b, input bank_state_t s);
    itf.ba_state_i[b*FSM_WIDTH2 +: FSM_WIDTH2] = s;
  endtask
  task automatic set_addr(input int b, input logic [ADDR_BITS-1:0] a);
    itf.ba_addr_i[b*ADDR_BITS +: ADDR_BITS] = a;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic tick();
    gnt_prev = ~itf.stall_o;
    @(posedge clk);
    #1;
    itf.ba_issue_i = gnt_prev | force_iss;
  endtask
  task automatic idle(input int n);
    for (int b = 0; b < 8; b++) set_st(b, B_IDLE);
    for (int i = 0; i < n; i++) begin
      mid();
      tick();
    end
  endtask
  initial begin
    exp3 = '{8'hBF, 8'hFF, 8'hFD, 8'hFF, 8'hEF, 8'hFF, 8'hBF};
    rst_n = 1'b0;
    force_iss = '0;
    itf.ba_issue_i = '0;
    itf.ba_addr_i = '0;
    for (int b = 0; b < 8; b++) set_st(b, B_IDLE);
    mid();
    check("rst_stall", 32'(itf.stall_o), 32'hFF);
    check("rst_cmd", 32'(itf.dram_cmd_o), 32'(NOP));
    check("rst_addr", 32'(itf.dram_addr_o), 32'h0);
    check("rst_ba", 32'(itf.dram_ba_o), 32'h0);
    check("rst_err", 32'(itf.proto_err_o), 32'h0);
    rst_n = 1'b1;
    tick();
    set_st(2, B_ACT_CHECK);
    mid(); check("t1_act_gnt", 32'(itf.stall_o), 32'hFB); tick();
    set_st(2, B_ACTIVE); set_addr(2, 13'h155);
    mid(); check("t1_c1_stall", 32'(itf.stall_o), 32'hFF); tick();
    set_st(2, B_READ_CHECK);
    mid();
    check("t1_bus_cmd", 32'(itf.dram_cmd_o), 32'(ACT));
    check("t1_bus_addr", 32'(itf.dram_addr_o), 32'h155);
    check("t1_bus_ba", 32'(itf.dram_ba_o), 32'h2);
    check("t1_rcd_stall", 32'(itf.stall_o), 32'hFF);
    tick();
    mid();
    check("t1_rd_gnt", 32'(itf.stall_o), 32'hFB);
    check("t1_cmd_nop", 32'(itf.dram_cmd_o), 32'(NOP));
    tick();
    set_st(2, B_READ);
    mid(); tick();
    mid(); check("t1_rd_bus", 32'(itf.dram_cmd_o), 32'(RD)); tick();
    idle(8);
    set_st(7, B_WRITE_CHECK); set_addr(7, 13'h400);
    mid(); check("t5_wr_gnt", 32'(itf.stall_o), 32'h7F); tick();
    set_st(7, B_WRITE);
    mid(); tick();
    set_st(7, B_ACT_CHECK);
    mid();
    check("t5_bus_cmd", 32'(itf.dram_cmd_o), 32'(WR));
    check("t5_bus_addr", 32'(itf.dram_addr_o), 32'h400);
    check("t5_bus_ba", 32'(itf.dram_ba_o), 32'h7);
    check("t5_ap_stall", 32'(itf.stall_o), 32'hFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      mid(); check("t5_ap_stall", 32'(itf.stall_o), 32'hFF); tick();
    end
    mid(); check("t5_ap_act", 32'(itf.stall_o), 32'h7F); tick();
    set_st(7, B_ACTIVE);
    mid(); tick();
    idle(8);
    set_st(0, B_ACT_CHECK); set_st(5, B_ACT_CHECK);
    mid(); check("t2_gnt0", 32'(itf.stall_o), 32'hFE); tick();
    set_st(0, B_ACTIVE);
    mid(); check("t2_rrd_stall", 32'(itf.stall_o), 32'hFF); tick();
    mid();
    check("t2_gnt5", 32'(itf.stall_o), 32'hDF);
    check("t2_bus_ba0", 32'(itf.dram_ba_o), 32'h0);
    check("t2_bus_act0", 32'(itf.dram_cmd_o), 32'(ACT));
    tick();
    set_st(5, B_ACTIVE);
    mid(); tick();
    mid(); check("t2_bus_ba5", 32'(itf.dram_ba_o), 32'h5); tick();
    idle(8);
    set_st(4, B_READ_CHECK);
    mid(); check("t3_prep", 32'(itf.stall_o), 32'hEF); tick();
    set_st(4, B_READ);
    mid(); tick();
    idle(3);
    set_st(1, B_READ_CHECK); set_st(4, B_READ_CHECK); set_st(6, B_READ_CHECK);
    for (int i = 0; i < 7; i++) begin
      mid(); check("t3_rr", 32'(itf.stall_o), 32'(exp3[i])); tick();
    end
    idle(4);
    set_st(3, B_ACT_CHECK);
    mid(); check("t4_act_gnt", 32'(itf.stall_o), 32'hF7); tick();
    set_st(3, B_ACTIVE);
    mid(); tick();
    set_st(3, B_PRE_CHECK);
    mid();
    check("t4_bus_act", 32'(itf.dram_cmd_o), 32'(ACT));
    check("t4_ras_stall", 32'(itf.stall_o), 32'hFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      mid(); check("t4_ras_stall", 32'(itf.stall_o), 32'hFF); tick();
    end
    mid(); check("t4_pre_gnt", 32'(itf.stall_o), 32'hF7); tick();
    set_st(3, B_PRE);
    mid(); tick();
    mid();
    check("t4_bus_pre", 32'(itf.dram_cmd_o), 32'(PRE));
    check("t4_bus_ba", 32'(itf.dram_ba_o), 32'h3);
    check("err_clean", 32'(itf.proto_err_o), 32'h0);
    tick();
    idle(4);
    mid();
    force_iss = 8'h09; set_addr(0, 13'h0AA); set_addr(3, 13'h033);
    tick();
    force_iss = '0;
    mid(); check("t7_err_pre", 32'(itf.proto_err_o), 32'h0); tick();
    mid();
    check("t7_err", 32'(itf.proto_err_o), 32'h1);
    check("t7_ba", 32'(itf.dram_ba_o), 32'h0);
    check("t7_addr", 32'(itf.dram_addr_o), 32'h0AA);
    tick();
    idle(3);
    mid(); check("t7_err_sticky", 32'(itf.proto_err_o), 32'h1); tick();
    set_st(1, B_ACT_CHECK);
    mid(); check("t6_act_gnt", 32'(itf.stall_o), 32'hFD); tick();
    set_st(1, B_ACTIVE);
    mid(); tick();
    mid();
    check("t6_bus_act", 32'(itf.dram_cmd_o), 32'(ACT));
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_cmd", 32'(itf.dram_cmd_o), 32'(NOP));
    check("t6_rst_stall", 32'(itf.stall_o), 32'hFF);
    check("t6_rst_err", 32'(itf.proto_err_o), 32'h0);
    check("t6_rst_ba", 32'(itf.dram_ba_o), 32'h0);
    for (int b = 0; b < 8; b++) set_st(b, B_IDLE);
    set_st(6, B_ACT_CHECK);
    tick();
    mid(); check("t6_rst_hold", 32'(itf.stall_o), 32'hFF);
    rst_n = 1'b1;
    #1 check("t6_first_gnt", 32'(itf.stall_o), 32'hBF);
    tick();
    mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
